// File: rtl/y_adder_seq_pkg.sv
// Shared encodings for the chunk-serial adder/subtractor.
// Imported by the top level and by the bench.
package y_adder_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } op_t;

endpackage

// File: rtl/y_adder_chunk.sv
// CHUNK-bit combinational ripple slice built from the 1-bit full-adder cell.
// c_msb (carry into the top bit) feeds signed-overflow detection.
module y_adder_fa (
    input  logic x,
    input  logic y,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = x ^ y ^ ci;
    assign co = (x & y) | (ci & (x ^ y));
endmodule

module y_adder_chunk #(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] x,
    input  logic [CHUNK-1:0] y,
    input  logic             ci,
    output logic [CHUNK-1:0] s,
    output logic             co,
    output logic             c_msb
);
    logic [CHUNK:0] w_c;

    assign w_c[0] = ci;

    for (genvar i = 0; i < CHUNK; i++) begin : g_bit
        y_adder_fa u_fa (
            .x  (x[i]),
            .y  (y[i]),
            .ci (w_c[i]),
            .s  (s[i]),
            .co (w_c[i+1])
        );
    end

    assign co    = w_c[CHUNK];
    assign c_msb = w_c[CHUNK-1];
endmodule

// File: rtl/y_adder_seq.sv
// Multi-cycle adder/subtractor: CHUNK bits per clock, LSB chunk first,
// through one shared ripple slice, with valid/ready on both sides.
module y_adder_seq
    import y_adder_seq_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] z,
    output logic             cout,
    output logic             ovf
);
    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

    if (WIDTH % CHUNK != 0) begin : g_chunk_check
        $error("y_adder_seq: WIDTH must be a multiple of CHUNK");
    end

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_z;
    logic             r_carry;
    logic             r_cout;
    logic             r_ovf;

    logic [CHUNK-1:0] w_x;
    logic [CHUNK-1:0] w_y;
    logic [CHUNK-1:0] w_s;
    logic             w_co;
    logic             w_c_msb;
    logic             w_last;
    op_t              w_op;

    assign w_op   = op_t'(sub);
    assign w_last = (r_cnt == LAST);

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        w_x = '0;
        w_y = '0;
        for (int k = 0; k < NCHUNK; k++) begin
            if (r_cnt == CW'(k)) begin
                w_x = r_a[k*CHUNK +: CHUNK];
                w_y = r_b[k*CHUNK +: CHUNK];
            end
        end
    end

    y_adder_chunk #(.CHUNK(CHUNK)) u_chunk (
        .x     (w_x),
        .y     (w_y),
        .ci    (r_carry),
        .s     (w_s),
        .co    (w_co),
        .c_msb (w_c_msb)
    );

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) w_state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (w_last) w_state_nxt = ST_DONE;
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    // NOTE: operand registers are reset too; they are few flops and keep the slice inputs deterministic.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_z     <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        // Subtract is a + ~b + !cin, so fold the inversion in at capture.
                        r_a     <= a;
                        r_b     <= (w_op == OP_SUB) ? ~b : b;
                        r_carry <= (w_op == OP_SUB) ? ~cin : cin;
                        r_cnt   <= '0;
                    end
                end
                ST_RUN: begin
                    for (int k = 0; k < NCHUNK; k++) begin
                        if (r_cnt == CW'(k)) r_z[k*CHUNK +: CHUNK] <= w_s;
                    end
                    r_carry <= w_co;
                    r_cnt   <= r_cnt + CW'(1);
                    if (w_last) begin
                        r_cout <= w_co;
                        r_ovf  <= w_co ^ w_c_msb;
                    end
                end
                default: ;
            endcase
        end
    end

    assign z    = r_z;
    assign cout = r_cout;
    assign ovf  = r_ovf;
endmodule

// File: tb/tb_y_adder_seq.sv
// Directed and random checks of y_adder_seq at CHUNK = 8, 32 and 1.
// Latency is counted in edges from the accept edge through the edge raising out_valid.
module tb_y_adder_seq;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         sub = 1'b0;
    logic         cin = 1'b0;
    logic [2:0]   in_valid = '0;
    logic [2:0]   out_ready = '0;
    logic [2:0]   in_ready;
    logic [2:0]   out_valid;
    logic [2:0]   cout_o;
    logic [2:0]   ovf_o;
    logic [W-1:0] z_o [3];

    int total = 0;
    int bad = 0;
    int nch [3] = '{4, 1, 32};

    always #5 clk = ~clk;

    y_adder_seq #(.WIDTH(W), .CHUNK(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .a(a), .b(b), .sub(sub), .cin(cin), .out_valid(out_valid[0]),
        .out_ready(out_ready[0]), .z(z_o[0]), .cout(cout_o[0]), .ovf(ovf_o[0])
    );

    y_adder_seq #(.WIDTH(W), .CHUNK(32)) u_dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .a(a), .b(b), .sub(sub), .cin(cin), .out_valid(out_valid[1]),
        .out_ready(out_ready[1]), .z(z_o[1]), .cout(cout_o[1]), .ovf(ovf_o[1])
    );

    y_adder_seq #(.WIDTH(W), .CHUNK(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .a(a), .b(b), .sub(sub), .cin(cin), .out_valid(out_valid[2]),
        .out_ready(out_ready[2]), .z(z_o[2]), .cout(cout_o[2]), .ovf(ovf_o[2])
    );

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Behavioural reference: {cout, ovf, z}; overflow from operand/result signs.
    function automatic logic [W+1:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                           input logic ms, input logic mc);
        logic [W-1:0] bb;
        logic [W:0]   sum;
        logic         ov;
        bb  = ms ? ~mb : mb;
        sum = {1'b0, ma} + {1'b0, bb} + {{W{1'b0}}, (ms ? ~mc : mc)};
        ov  = (ma[W-1] == bb[W-1]) && (sum[W-1] != ma[W-1]);
        return {sum[W], ov, sum[W-1:0]};
    endfunction

    // Called at a non-edge time with instance idx in IDLE; returns one full transaction.
    task automatic run_op(input int idx, input logic [W-1:0] ta, input logic [W-1:0] tb,
                          input logic ts, input logic tc,
                          output logic [W-1:0] rz, output logic rc, output logic ro,
                          output int lat);
        check($sformatf("in_ready_before_%0d", idx), in_ready[idx], 1);
        a = ta; b = tb; sub = ts; cin = tc;
        in_valid[idx] = 1'b1;
        @(posedge clk); #1;
        in_valid[idx] = 1'b0;
        lat = 1;
        while (out_valid[idx] !== 1'b1 && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        check($sformatf("out_valid_wait_%0d", idx), out_valid[idx], 1);
        rz = z_o[idx];
        rc = cout_o[idx];
        ro = ovf_o[idx];
        out_ready[idx] = 1'b1;
        @(posedge clk); #1;
        out_ready[idx] = 1'b0;
    endtask

    task automatic directed(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb,
                            input logic ts, input logic tc, input logic [W-1:0] ez,
                            input logic ec, input logic eo);
        logic [W-1:0] rz;
        logic         rc, ro;
        int           lat;
        run_op(0, ta, tb, ts, tc, rz, rc, ro, lat);
        check({tag, "_z"}, rz, ez);
        check({tag, "_cout"}, rc, ec);
        check({tag, "_ovf"}, ro, eo);
        check({tag, "_lat"}, lat, 5);
    endtask

    initial begin
        logic [W-1:0] ra, rb, rz;
        logic         rs, rcin, rc, ro;
        logic [W+1:0] exp;
        int           lat;

        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("rst_in_ready_%0d", i), in_ready[i], 1);
            check($sformatf("rst_out_valid_%0d", i), out_valid[i], 0);
            check($sformatf("rst_z_%0d", i), z_o[i], 0);
            check($sformatf("rst_cout_%0d", i), cout_o[i], 0);
            check($sformatf("rst_ovf_%0d", i), ovf_o[i], 0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        directed("add_wrap", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
        directed("add_ovf",  32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
        directed("add_cin",  32'd5,         32'd7,         1'b0, 1'b1, 32'd13,        1'b0, 1'b0);
        directed("sub_neg",  32'd5,         32'd7,         1'b1, 1'b0, 32'hFFFF_FFFE, 1'b0, 1'b0);
        directed("sub_ovf",  32'h8000_0000, 32'h0000_0001, 1'b1, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b1);

        // Backpressure: park in DONE and offer new operands that must be ignored.
        a = 32'h8000_0000; b = 32'h0000_0001; sub = 1'b1; cin = 1'b0;
        in_valid[0] = 1'b1;
        @(posedge clk); #1;
        in_valid[0] = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("bp_reach_done", out_valid[0], 1);
        a = 32'h1111_1111; b = 32'h2222_2222; sub = 1'b0; cin = 1'b1;
        in_valid[0] = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            check("bp_z", z_o[0], 32'h7FFF_FFFF);
            check("bp_cout", cout_o[0], 1);
            check("bp_ovf", ovf_o[0], 1);
            check("bp_in_ready", in_ready[0], 0);
            check("bp_out_valid", out_valid[0], 1);
        end
        in_valid[0] = 1'b0;
        out_ready[0] = 1'b1;
        @(posedge clk); #1;
        out_ready[0] = 1'b0;
        check("bp_idle_in_ready", in_ready[0], 1);
        check("bp_idle_out_valid", out_valid[0], 0);
        directed("bp_next", 32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0001_0000, 1'b0, 1'b0);

        // Reset after chunk 1 of a run.
        a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; sub = 1'b0; cin = 1'b1;
        in_valid[0] = 1'b1;
        @(posedge clk); #1;
        in_valid[0] = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("mid_busy", in_ready[0], 0);
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", out_valid[0], 0);
        check("mid_rst_z", z_o[0], 0);
        check("mid_rst_in_ready", in_ready[0], 1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        directed("after_rst", 32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 32'h2345_6789, 1'b0, 1'b0);

        for (int idx = 0; idx < 3; idx++) begin
            for (int n = 0; n < 200; n++) begin
                ra   = $urandom;
                rb   = $urandom;
                rs   = 1'($urandom_range(0, 1));
                rcin = 1'($urandom_range(0, 1));
                exp  = model(ra, rb, rs, rcin);
                run_op(idx, ra, rb, rs, rcin, rz, rc, ro, lat);
                check($sformatf("rnd%0d_z a=%h b=%h s=%0d c=%0d", idx, ra, rb, rs, rcin), rz, exp[W-1:0]);
                check($sformatf("rnd%0d_cout", idx), rc, exp[W+1]);
                check($sformatf("rnd%0d_ovf", idx), ro, exp[W]);
                check($sformatf("rnd%0d_lat", idx), lat, nch[idx] + 1);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
